// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC bus-cycle sequencer.
// Phase encoding and default parameters live here.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_AHOLD  = 3'd2,
        S_STROBE = 3'd3,
        S_RECOV  = 3'd4,
        S_DONE   = 3'd5
    } phase_t;

    localparam int DEF_BUS_W    = 8;
    localparam int DEF_CNT_W    = 5;
    localparam int DEF_T_AS     = 2;
    localparam int DEF_T_AH     = 1;
    localparam int DEF_T_STROBE = 10;
    localparam int DEF_T_REC    = 10;

endpackage

// File: rtl/bus_phase_timer.sv
// Down-counting phase timer for the bus-cycle sequencer.
// Load wins over enable; the counter parks at zero.
module bus_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Reload on phase entry, otherwise count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_cycle_seq.sv
// Single read/write bus-cycle sequencer for a muxed address/data part.
// All outputs are registered from the next state so strobes are glitch-free.
module rtc_bus_cycle_seq
    import rtc_bus_pkg::*;
#(
    parameter int BUS_W    = DEF_BUS_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T_AS     = DEF_T_AS,
    parameter int T_AH     = DEF_T_AH,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_REC    = DEF_T_REC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             we,
    input  logic [BUS_W-1:0] addr,
    input  logic [BUS_W-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [BUS_W-1:0] rdata,
    output logic             lcs,
    output logic             lrd,
    output logic             lwr,
    output logic             lad,
    output logic [BUS_W-1:0] bus_out,
    output logic             bus_oe,
    input  logic [BUS_W-1:0] bus_in
);

    localparam int T_MAX = 1 << CNT_W;
    localparam bit T_OK =
        (T_AS >= 1) && (T_AS < T_MAX) &&
        (T_AH >= 1) && (T_AH < T_MAX) &&
        (T_STROBE >= 1) && (T_STROBE < T_MAX) &&
        (T_REC >= 1) && (T_REC < T_MAX);

    if (!T_OK) begin : g_bad_timing
        $error("rtc_bus_cycle_seq: T_* must be in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LD_AS  = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LD_AH  = CNT_W'(T_AH - 1);
    localparam logic [CNT_W-1:0] LD_STB = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] LD_REC = CNT_W'(T_REC - 1);

    phase_t           state;
    phase_t           state_nxt;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    logic             accept;
    logic             we_q;
    logic [BUS_W-1:0] addr_q;
    logic [BUS_W-1:0] wdata_q;
    logic             we_nxt;
    logic [BUS_W-1:0] addr_nxt;
    logic [BUS_W-1:0] wdata_nxt;

    logic             lcs_nxt;
    logic             lrd_nxt;
    logic             lwr_nxt;
    logic             lad_nxt;
    logic             oe_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [BUS_W-1:0] out_nxt;

    bus_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .enable  (tmr_en),
        .zero    (tmr_zero)
    );

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign tmr_en = (state == S_ADDR) || (state == S_AHOLD) ||
                    (state == S_STROBE) || (state == S_RECOV);

    // Next phase, timer reload and operand selection.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        we_nxt    = accept ? we    : we_q;
        addr_nxt  = accept ? addr  : addr_q;
        wdata_nxt = accept ? wdata : wdata_q;
        unique case (state)
            S_IDLE, S_DONE: begin
                state_nxt = (state == S_DONE) ? S_IDLE : S_IDLE;
                if (start) begin
                    state_nxt = S_ADDR;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_AS;
                end
            end
            S_ADDR: if (tmr_zero) begin
                state_nxt = S_AHOLD;
                tmr_load  = 1'b1;
                tmr_val   = LD_AH;
            end
            S_AHOLD: if (tmr_zero) begin
                state_nxt = S_STROBE;
                tmr_load  = 1'b1;
                tmr_val   = LD_STB;
            end
            S_STROBE: if (tmr_zero) begin
                state_nxt = S_RECOV;
                tmr_load  = 1'b1;
                tmr_val   = LD_REC;
            end
            S_RECOV: if (tmr_zero) begin
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Decode the bus pins for the phase being entered.
    always_comb begin
        lcs_nxt  = 1'b1;
        lrd_nxt  = 1'b1;
        lwr_nxt  = 1'b1;
        lad_nxt  = 1'b1;
        oe_nxt   = 1'b0;
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = 1'b0;
        out_nxt  = '0;
        unique case (state_nxt)
            S_ADDR: begin
                lcs_nxt = 1'b0;
                lad_nxt = 1'b0;
                oe_nxt  = 1'b1;
                out_nxt = addr_nxt;
            end
            S_AHOLD: begin
                lcs_nxt = 1'b0;
                oe_nxt  = 1'b1;
                out_nxt = addr_nxt;
            end
            S_STROBE: begin
                lcs_nxt = 1'b0;
                if (we_nxt) begin
                    lwr_nxt = 1'b0;
                    oe_nxt  = 1'b1;
                    out_nxt = wdata_nxt;
                end else begin
                    lrd_nxt = 1'b0;
                end
            end
            S_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Phase register, operand capture, read capture and pin registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            lcs     <= 1'b1;
            lrd     <= 1'b1;
            lwr     <= 1'b1;
            lad     <= 1'b1;
            bus_oe  <= 1'b0;
            bus_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            if ((state == S_STROBE) && tmr_zero && !we_q) begin
                rdata <= bus_in;
            end
            lcs     <= lcs_nxt;
            lrd     <= lrd_nxt;
            lwr     <= lwr_nxt;
            lad     <= lad_nxt;
            bus_oe  <= oe_nxt;
            bus_out <= out_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_rtc_bus_cycle_seq.sv
// Directed bench for rtc_bus_cycle_seq: default timing plus an all-ones
// timing instance, per-cycle snapshots checked against hand-derived values.
module tb_rtc_bus_cycle_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start2;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] bus_in;

    logic       busy, done, lcs, lrd, lwr, lad, bus_oe;
    logic [7:0] rdata, bus_out;
    logic       busy2, done2, lcs2, lrd2, lwr2, lad2, bus_oe2;
    logic [7:0] rdata2, bus_out2;

    logic       lcs_a [0:127];
    logic       lrd_a [0:127];
    logic       lwr_a [0:127];
    logic       lad_a [0:127];
    logic       oe_a  [0:127];
    logic       busy_a[0:127];
    logic       done_a[0:127];
    logic [7:0] out_a [0:127];
    logic       lcs2_a[0:127];
    logic       lrd2_a[0:127];
    logic       lad2_a[0:127];
    logic       oe2_a [0:127];
    logic       done2_a[0:127];
    logic [7:0] out2_a[0:127];

    int tests_run;
    int tests_failed;

    rtc_bus_cycle_seq dut (
        .clk(clk), .reset(reset), .start(start), .we(we),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .lcs(lcs), .lrd(lrd), .lwr(lwr), .lad(lad),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    rtc_bus_cycle_seq #(
        .T_AS(1), .T_AH(1), .T_STROBE(1), .T_REC(1)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .we(we),
        .addr(addr), .wdata(wdata), .busy(busy2), .done(done2),
        .rdata(rdata2), .lcs(lcs2), .lrd(lrd2), .lwr(lwr2), .lad(lad2),
        .bus_out(bus_out2), .bus_oe(bus_oe2), .bus_in(bus_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot both DUTs at each falling edge; index n = edges since accept.
    task automatic sample(input int ncyc, input bit hold, input int pulse_at);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            lcs_a[n]   = lcs;
            lrd_a[n]   = lrd;
            lwr_a[n]   = lwr;
            lad_a[n]   = lad;
            oe_a[n]    = bus_oe;
            busy_a[n]  = busy;
            done_a[n]  = done;
            out_a[n]   = bus_out;
            lcs2_a[n]  = lcs2;
            lrd2_a[n]  = lrd2;
            lad2_a[n]  = lad2;
            oe2_a[n]   = bus_oe2;
            done2_a[n] = done2;
            out2_a[n]  = bus_out2;
            start  = hold || (n == pulse_at);
            start2 = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0; start2 = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; bus_in = '0;
        #12;
        tests_run++;
        if ({lcs, lrd, lwr, lad} !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b want 1111", {lcs, lrd, lwr, lad});
        end
        tests_run++;
        if ({bus_oe, busy, done} !== 3'b000 || bus_out !== 8'h00 || rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: oe/busy/done=%b out=%h rdata=%h want 000/00/00",
                     {bus_oe, busy, done}, bus_out, rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        int lad_lo = 0, lrd_lo = 0, bad_a = 0, bad_s = 0, bad_x = 0;
        int nd = 0, fd = -1;
        we = 1'b0; addr = 8'h0A; bus_in = 8'h5C; start = 1'b1;
        sample(30, 1'b0, 0);
        addr = 8'hFF;
        for (int n = 1; n <= 30; n++) begin
            if (!lad_a[n]) begin
                lad_lo++;
                if (out_a[n] !== 8'h0A || oe_a[n] !== 1'b1) bad_a++;
            end
            if (!lrd_a[n]) begin
                lrd_lo++;
                if (oe_a[n] !== 1'b0 || lcs_a[n] !== 1'b0) bad_s++;
            end
            if ((!lrd_a[n] && !lwr_a[n]) || (!lad_a[n] && (!lrd_a[n] || !lwr_a[n]))) bad_x++;
            if (done_a[n]) begin
                nd++;
                if (fd < 0) fd = n - 1;
            end
        end
        tests_run++;
        if (lad_lo !== 2) begin tests_failed++; $display("FAIL read_lad_cycles: got %0d want 2", lad_lo); end
        tests_run++;
        if (bad_a !== 0) begin tests_failed++; $display("FAIL read_addr_drive: got %0d bad cycles want 0", bad_a); end
        tests_run++;
        if (lrd_lo !== 10) begin tests_failed++; $display("FAIL read_lrd_cycles: got %0d want 10", lrd_lo); end
        tests_run++;
        if (bad_s !== 0) begin tests_failed++; $display("FAIL read_strobe_oe: got %0d bad cycles want 0", bad_s); end
        tests_run++;
        if (bad_x !== 0) begin tests_failed++; $display("FAIL read_overlap: got %0d bad cycles want 0", bad_x); end
        tests_run++;
        if (fd !== 23 || nd !== 1) begin tests_failed++; $display("FAIL read_done: got cycle %0d count %0d want 23/1", fd, nd); end
        tests_run++;
        if (rdata !== 8'h5C) begin tests_failed++; $display("FAIL read_rdata: got %h want 5c", rdata); end
    endtask

    task automatic test_write();
        int lwr_lo = 0, lrd_lo = 0, bad_w = 0, fd = -1;
        we = 1'b1; addr = 8'h0B; wdata = 8'h82; bus_in = 8'h11; start = 1'b1;
        sample(30, 1'b0, 0);
        for (int n = 1; n <= 30; n++) begin
            if (!lwr_a[n]) begin
                lwr_lo++;
                if (out_a[n] !== 8'h82 || oe_a[n] !== 1'b1) bad_w++;
            end
            if (!lrd_a[n]) lrd_lo++;
            if (done_a[n] && fd < 0) fd = n - 1;
        end
        tests_run++;
        if (lwr_lo !== 10) begin tests_failed++; $display("FAIL write_lwr_cycles: got %0d want 10", lwr_lo); end
        tests_run++;
        if (bad_w !== 0) begin tests_failed++; $display("FAIL write_data_drive: got %0d bad cycles want 0", bad_w); end
        tests_run++;
        if (lrd_lo !== 0) begin tests_failed++; $display("FAIL write_lrd_idle: got %0d low cycles want 0", lrd_lo); end
        tests_run++;
        if (rdata !== 8'h5C) begin tests_failed++; $display("FAIL write_rdata_hold: got %h want 5c", rdata); end
        tests_run++;
        if (fd !== 23) begin tests_failed++; $display("FAIL write_done: got cycle %0d want 23", fd); end
    endtask

    task automatic test_back_to_back();
        int busy_lo = 0, nd = 0, d1 = -1, d2 = -1;
        we = 1'b0; addr = 8'h2A; bus_in = 8'h66; start = 1'b1;
        sample(60, 1'b1, 0);
        for (int n = 1; n <= 60; n++) begin
            if (!busy_a[n]) busy_lo++;
            if (done_a[n]) begin
                nd++;
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
            end
        end
        tests_run++;
        if (busy_lo !== 0) begin tests_failed++; $display("FAIL b2b_busy: got %0d low cycles want 0", busy_lo); end
        tests_run++;
        if (nd !== 2 || d1 !== 24 || d2 !== 48) begin
            tests_failed++;
            $display("FAIL b2b_done: got count %0d at %0d,%0d want 2 at 24,48", nd, d1, d2);
        end
        tests_run++;
        if (lad_a[25] !== 1'b0 || lcs_a[25] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_addr: got lad=%b lcs=%b want 0/0", lad_a[25], lcs_a[25]);
        end
        sample(40, 1'b0, 0);
        tests_run++;
        if (busy_a[40] !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got busy=%b want 0", busy_a[40]); end
    endtask

    task automatic test_start_ignored();
        int nd = 0, fd = -1;
        we = 1'b0; addr = 8'h21; bus_in = 8'h3C; start = 1'b1;
        sample(40, 1'b0, 6);
        for (int n = 1; n <= 40; n++) begin
            if (done_a[n]) begin
                nd++;
                if (fd < 0) fd = n - 1;
            end
        end
        tests_run++;
        if (nd !== 1 || fd !== 23) begin
            tests_failed++;
            $display("FAIL ignore_start: got count %0d first %0d want 1/23", nd, fd);
        end
        tests_run++;
        if (rdata !== 8'h3C) begin tests_failed++; $display("FAIL ignore_rdata: got %h want 3c", rdata); end
    endtask

    task automatic test_reset_abort();
        int nd = 0, fd = -1;
        we = 1'b0; addr = 8'h44; bus_in = 8'h99; start = 1'b1;
        sample(6, 1'b0, 0);
        tests_run++;
        if (lrd_a[6] !== 1'b0) begin tests_failed++; $display("FAIL abort_pre_strobe: got lrd=%b want 0", lrd_a[6]); end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({lcs, lrd, lwr, lad} !== 4'hF) begin
            tests_failed++;
            $display("FAIL abort_strobes: got %b want 1111", {lcs, lrd, lwr, lad});
        end
        tests_run++;
        if ({bus_oe, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort_oe_busy_done: got %b want 000", {bus_oe, busy, done});
        end
        sample(4, 1'b0, 0);
        for (int n = 1; n <= 4; n++) if (done_a[n] || busy_a[n]) nd++;
        tests_run++;
        if (nd !== 0) begin tests_failed++; $display("FAIL abort_quiet: got %0d active cycles want 0", nd); end
        reset = 1'b1;
        @(negedge clk);
        nd = 0;
        we = 1'b0; addr = 8'h55; bus_in = 8'hA5; start = 1'b1;
        sample(30, 1'b0, 0);
        for (int n = 1; n <= 30; n++) begin
            if (done_a[n]) begin
                nd++;
                if (fd < 0) fd = n - 1;
            end
        end
        tests_run++;
        if (nd !== 1 || fd !== 23 || rdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL abort_recover: got count %0d at %0d rdata %h want 1/23/a5", nd, fd, rdata);
        end
    endtask

    task automatic test_min_timing();
        int nd = 0, fd = -1;
        we = 1'b0; addr = 8'h0C; bus_in = 8'h7E; start = 1'b0; start2 = 1'b1;
        sample(8, 1'b0, 0);
        for (int n = 1; n <= 8; n++) begin
            if (done2_a[n]) begin
                nd++;
                if (fd < 0) fd = n - 1;
            end
        end
        tests_run++;
        if (lad2_a[1] !== 1'b0 || oe2_a[1] !== 1'b1 || out2_a[1] !== 8'h0C) begin
            tests_failed++;
            $display("FAIL min_addr: got lad=%b oe=%b out=%h want 0/1/0c", lad2_a[1], oe2_a[1], out2_a[1]);
        end
        tests_run++;
        if (lad2_a[2] !== 1'b1 || lcs2_a[2] !== 1'b0 || lrd2_a[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL min_ahold: got lad=%b lcs=%b lrd=%b want 1/0/1", lad2_a[2], lcs2_a[2], lrd2_a[2]);
        end
        tests_run++;
        if (lrd2_a[3] !== 1'b0 || lrd2_a[4] !== 1'b1 || lcs2_a[4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL min_strobe: got lrd3=%b lrd4=%b lcs4=%b want 0/1/1", lrd2_a[3], lrd2_a[4], lcs2_a[4]);
        end
        tests_run++;
        if (nd !== 1 || fd !== 4) begin
            tests_failed++;
            $display("FAIL min_done: got count %0d at %0d want 1/4", nd, fd);
        end
        tests_run++;
        if (rdata2 !== 8'h7E) begin tests_failed++; $display("FAIL min_rdata: got %h want 7e", rdata2); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_min_timing();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
